// File: rtl/patgen_pkg.sv
// Shared definitions for the video test-pattern source: mode codes, bar colours
// and pipeline latency.
package patgen_pkg;

    localparam logic [1:0] MODE_BORDER = 2'd0;
    localparam logic [1:0] MODE_CHECK  = 2'd1;
    localparam logic [1:0] MODE_BARS   = 2'd2;
    localparam logic [1:0] MODE_GRAD   = 2'd3;

    // Cycles from i_* to the matching o_* sample.
    localparam int PATGEN_LAT = 2;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // Bar colour as {r, g, b}: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/patgen_bar_counter.sv
// Divider-free colour-bar index: a column counter that wraps every BAR_W active
// pixels and bumps a bar index saturating at 7.
module patgen_bar_counter #(
    parameter int BAR_W = 80,
    parameter int XYW   = 11
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           de,
    input  logic [XYW-1:0] x,
    output logic [2:0]     idx
);

    localparam int CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic             wrap;

    // The registers hold the position of the previous active pixel, so the
    // next-state value is the position of the pixel being presented now.
    assign wrap = (cnt_q == CNT_W'(BAR_W - 1));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (x == '0) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd7) ? 3'd7 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (de) begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_d;

endmodule

// File: rtl/pattern_generator.sv
// Two-stage video test-pattern source (border, checker, bars, gradient).
// Build option PATGEN_SCROLL_EN scrolls the checker and gradient by frame count.
module pattern_generator
    import patgen_pkg::*;
#(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int XYW        = 11,
    parameter int CW         = 8,
    parameter int CHECK_LOG2 = 3,
    parameter int BAR_W      = 80
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_de,
    input  logic           i_hs,
    input  logic           i_vs,
    input  logic [XYW-1:0] i_x,
    input  logic [XYW-1:0] i_y,
    input  logic [1:0]     i_mode,
    output logic           o_de,
    output logic           o_hs,
    output logic           o_vs,
    output logic [CW-1:0]  o_r,
    output logic [CW-1:0]  o_g,
    output logic [CW-1:0]  o_b
);

    logic [1:0]     rst_sync;
    logic           rstn;
    logic           vs_q;
    logic           vs_rise;
    logic [1:0]     mode_q;
    logic [7:0]     frame_cnt;
    logic [XYW-1:0] x_eff;
    logic [2:0]     bar_idx;
    logic           border_on;
    logic           check_on;

    sync_t          s1_sync;
    logic [1:0]     s1_mode;
    logic           s1_on;
    logic [2:0]     s1_idx;
    logic [CW-1:0]  s1_gr;
    logic [CW-1:0]  s1_gg;
    logic [CW-1:0]  s1_gb;
    logic [2:0]     bar_rgb;
    logic [CW-1:0]  r_d;
    logic [CW-1:0]  g_d;
    logic [CW-1:0]  b_d;

    // Asynchronous assert, release synchronised to i_clk.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rstn = rst_sync[1];

    assign vs_rise = i_vs & ~vs_q;

    // The pixel coinciding with the vs edge still sees the old mode.
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            vs_q      <= 1'b0;
            mode_q    <= MODE_BORDER;
            frame_cnt <= 8'd0;
        end else begin
            vs_q <= i_vs;
            if (vs_rise) begin
                mode_q    <= i_mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef PATGEN_SCROLL_EN
    assign x_eff = i_x + XYW'(frame_cnt);
`else
    assign x_eff = i_x;
`endif

    patgen_bar_counter #(
        .BAR_W (BAR_W),
        .XYW   (XYW)
    ) u_bar_counter (
        .i_clk  (i_clk),
        .i_rstn (rstn),
        .de     (i_de),
        .x      (i_x),
        .idx    (bar_idx)
    );

    assign border_on = (i_x == '0) || (i_x == XYW'(H_ACT - 1)) ||
                       (i_y == '0) || (i_y == XYW'(V_ACT - 1));
    assign check_on  = x_eff[CHECK_LOG2] ^ i_y[CHECK_LOG2];

    // Stage 1: pattern class, on/off decision and bar index.
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            s1_sync <= '0;
            s1_mode <= MODE_BORDER;
            s1_on   <= 1'b0;
            s1_idx  <= 3'd0;
            s1_gr   <= '0;
            s1_gg   <= '0;
            s1_gb   <= '0;
        end else begin
            s1_sync <= '{de: i_de, hs: i_hs, vs: i_vs};
            s1_mode <= mode_q;
            s1_on   <= (mode_q == MODE_CHECK) ? check_on : border_on;
            s1_idx  <= bar_idx;
            s1_gr   <= CW'(x_eff);
            s1_gg   <= CW'(i_y);
            s1_gb   <= CW'(frame_cnt);
        end
    end

    assign bar_rgb = bar_colour(s1_idx);

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s1_sync.de) begin
            case (s1_mode)
                MODE_BARS: begin
                    r_d = {CW{bar_rgb[2]}};
                    g_d = {CW{bar_rgb[1]}};
                    b_d = {CW{bar_rgb[0]}};
                end
                MODE_GRAD: begin
                    r_d = s1_gr;
                    g_d = s1_gg;
                    b_d = s1_gb;
                end
                default: begin
                    r_d = {CW{s1_on}};
                    g_d = {CW{s1_on}};
                    b_d = {CW{s1_on}};
                end
            endcase
        end
    end

    // Stage 2: colour and delayed sync.
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            o_de <= 1'b0;
            o_hs <= 1'b0;
            o_vs <= 1'b0;
            o_r  <= '0;
            o_g  <= '0;
            o_b  <= '0;
        end else begin
            o_de <= s1_sync.de;
            o_hs <= s1_sync.hs;
            o_vs <= s1_sync.vs;
            o_r  <= r_d;
            o_g  <= g_d;
            o_b  <= b_d;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: randomized pixels scored against a reference
// model of the pattern rules, plus spot values at notable pixels.
module tb_pattern_generator;

    localparam int H_ACT      = 640;
    localparam int V_ACT      = 480;
    localparam int XYW        = 11;
    localparam int CW         = 8;
    localparam int CHECK_LOG2 = 3;
    localparam int BAR_W      = 80;
    localparam int W          = 3 + 3 * CW;

    logic           i_clk = 1'b0;
    logic           i_rstn;
    logic           i_de;
    logic           i_hs;
    logic           i_vs;
    logic [XYW-1:0] i_x;
    logic [XYW-1:0] i_y;
    logic [1:0]     i_mode;
    logic           o_de;
    logic           o_hs;
    logic           o_vs;
    logic [CW-1:0]  o_r;
    logic [CW-1:0]  o_g;
    logic [CW-1:0]  o_b;

    typedef struct {
        int x;
        int y;
        int mode;
        int fc;
        bit de;
    } tag_t;

    logic [W-1:0] exp_q[$];
    tag_t         tag_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_mode;
    int           m_fc;
    bit           m_prev_vs;

    always #5 i_clk = ~i_clk;

    pattern_generator #(
        .H_ACT      (H_ACT),
        .V_ACT      (V_ACT),
        .XYW        (XYW),
        .CW         (CW),
        .CHECK_LOG2 (CHECK_LOG2),
        .BAR_W      (BAR_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_de   (i_de),
        .i_hs   (i_hs),
        .i_vs   (i_vs),
        .i_x    (i_x),
        .i_y    (i_y),
        .i_mode (i_mode),
        .o_de   (o_de),
        .o_hs   (o_hs),
        .o_vs   (o_vs),
        .o_r    (o_r),
        .o_g    (o_g),
        .o_b    (o_b)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] fill(input bit b);
        return b ? {CW{1'b1}} : {CW{1'b0}};
    endfunction

    // Reference: pattern colour from screen position, mode and frame count.
    function automatic logic [W-1:0] model(input bit de, input bit hs, input bit vs,
                                           input int x, input int y, input int mode, input int fc);
        logic [CW-1:0] r, g, b;
        logic [XYW-1:0] xs;
        int idx;
        bit on;
        xs = XYW'(x);
`ifdef PATGEN_SCROLL_EN
        xs = XYW'((x + fc) % (1 << XYW));
`endif
        r = '0; g = '0; b = '0;
        case (mode)
            0: begin
                on = (x == 0) || (x == H_ACT - 1) || (y == 0) || (y == V_ACT - 1);
                r = fill(on); g = fill(on); b = fill(on);
            end
            1: begin
                on = (((int'(xs) >> CHECK_LOG2) + (y >> CHECK_LOG2)) % 2) == 1;
                r = fill(on); g = fill(on); b = fill(on);
            end
            2: begin
                idx = x / BAR_W;
                if (idx > 7) idx = 7;
                case (idx)
                    0: begin r = fill(1); g = fill(1); b = fill(1); end
                    1: begin r = fill(1); g = fill(1); b = fill(0); end
                    2: begin r = fill(0); g = fill(1); b = fill(1); end
                    3: begin r = fill(0); g = fill(1); b = fill(0); end
                    4: begin r = fill(1); g = fill(0); b = fill(1); end
                    5: begin r = fill(1); g = fill(0); b = fill(0); end
                    6: begin r = fill(0); g = fill(0); b = fill(1); end
                    default: begin r = fill(0); g = fill(0); b = fill(0); end
                endcase
            end
            default: begin
                r = CW'(int'(xs) % (1 << CW));
                g = CW'(y % (1 << CW));
                b = CW'(fc % (1 << CW));
            end
        endcase
        if (!de) begin
            r = '0; g = '0; b = '0;
        end
        return {de, hs, vs, r, g, b};
    endfunction

    // Known colours at notable pixels, as 24-bit RGB.
    function automatic bit spot(input tag_t t, output logic [23:0] rgb);
        rgb = 24'h0;
        if (!t.de) return 0;
        case (t.mode)
            0: begin
                if ((t.x == 0 && t.y == 0) || (t.x == 639 && t.y == 240) || (t.x == 320 && t.y == 479)) begin
                    rgb = 24'hFFFFFF; return 1;
                end
                if (t.x == 320 && t.y == 240) begin
                    rgb = 24'h000000; return 1;
                end
            end
            1: begin
`ifdef PATGEN_SCROLL_EN
                if (t.fc == 8 && t.x == 0 && t.y == 0) begin rgb = 24'hFFFFFF; return 1; end
`else
                if (t.x == 8 && t.y == 0) begin rgb = 24'hFFFFFF; return 1; end
                if ((t.x == 8 && t.y == 8) || (t.x == 7 && t.y == 7)) begin rgb = 24'h000000; return 1; end
`endif
            end
            2: begin
                if (t.x == 0)   begin rgb = 24'hFFFFFF; return 1; end
                if (t.x == 80)  begin rgb = 24'hFFFF00; return 1; end
                if (t.x == 559) begin rgb = 24'h0000FF; return 1; end
                if (t.x >= 560) begin rgb = 24'h000000; return 1; end
            end
            default: begin
`ifndef PATGEN_SCROLL_EN
                if (t.x == 5 && t.y == 9 && t.fc == 255) begin rgb = 24'h0509FF; return 1; end
                if (t.x == 5 && t.y == 9 && t.fc == 0)   begin rgb = 24'h050900; return 1; end
`endif
            end
        endcase
        return 0;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_fc      = 0;
        m_prev_vs = 0;
        exp_q.delete();
        tag_q.delete();
    endtask

    // One pixel clock: score the output due now, then present the next inputs.
    task automatic drive(input bit de, input bit hs, input bit vs, input int x, input int y);
        logic [W-1:0] got;
        logic [23:0]  srgb;
        tag_t         t;
        @(negedge i_clk);
        if (exp_q.size() == 2) begin
            got = {o_de, o_hs, o_vs, o_r, o_g, o_b};
            t   = tag_q.pop_front();
            check($sformatf("pix m%0d (%0d,%0d)", t.mode, t.x, t.y), got, exp_q.pop_front());
            if (spot(t, srgb))
                check($sformatf("spot m%0d f%0d (%0d,%0d)", t.mode, t.fc, t.x, t.y),
                      W'(got[3*CW-1:0]), W'(srgb));
        end
        i_de = de;
        i_hs = hs;
        i_vs = vs;
        i_x  = XYW'(x);
        i_y  = XYW'(y);
        exp_q.push_back(model(de, hs, vs, x, y, m_mode, m_fc));
        tag_q.push_back('{x: x, y: y, mode: m_mode, fc: m_fc, de: de});
        if (vs && !m_prev_vs) begin
            m_mode = int'(i_mode);
            m_fc   = (m_fc + 1) % 256;
        end
        m_prev_vs = vs;
    endtask

    task automatic px(input int x, input int y);
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, x, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic vs_frame();
        drive(1'b0, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Full active line with random blanking gaps; x advances only on de cycles.
    task automatic line(input int y, input int gap_pct);
        for (int x = 0; x < H_ACT; x++) begin
            if ($urandom_range(0, 99) < gap_pct)
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, x, y);
            px(x, y);
        end
    endtask

    task automatic random_pixels(input int n);
        for (int i = 0; i < n; i++)
            px($urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check("rst_out", {o_de, o_hs, o_vs, o_r, o_g, o_b}, '0);
        model_reset();
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
        idle(4);
    endtask

    initial begin
        i_rstn = 1'b0;
        i_de   = 1'b0;
        i_hs   = 1'b0;
        i_vs   = 1'b0;
        i_x    = '0;
        i_y    = '0;
        i_mode = 2'd0;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
        idle(4);

        // Border pixels in flight, then reset mid-line.
        px(0, 0); px(1, 0); px(2, 0);
        pulse_reset();

        // Border frame, including a mid-frame mode request that must be ignored.
        px(0, 0); px(639, 240); px(320, 479); px(320, 240);
        random_pixels(40);
        i_mode = 2'd2;
        px(320, 240); px(639, 100);
        random_pixels(20);

        // Bars.
        vs_frame();
        line(10, 20);
        line(11, 0);

        // Checker.
        i_mode = 2'd1;
        vs_frame();
        px(8, 0); px(8, 8); px(7, 7);
        random_pixels(30);

        // Gradient across a frame-counter wrap.
        i_mode = 2'd3;
        for (int f = 0; f < 260; f++) begin
            vs_frame();
            px(5, 9);
            random_pixels(1);
        end

        // Reset returns to border and zero frame count; then scroll check point.
        pulse_reset();
        px(0, 0); px(639, 240);
        i_mode = 2'd1;
        for (int f = 0; f < 8; f++) vs_frame();
        px(0, 0); px(8, 0); px(8, 8); px(7, 7);
        random_pixels(20);

        // Random frames with random mode requests, some changed mid-frame.
        for (int f = 0; f < 6; f++) begin
            i_mode = 2'($urandom_range(0, 3));
            vs_frame();
            i_mode = 2'($urandom_range(0, 3));
            line($urandom_range(0, V_ACT - 1), 15);
            if (m_mode != 2) random_pixels(30);
        end

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_generator.md
# pattern_generator

Parametrised video test-pattern source. It replaces the single-bit border generator in the DVI transmit path. It sits between the video timing generator (which supplies i_de/i_hs/i_vs/i_x/i_y) and the TMDS encoders, and drives CW-bit RGB. It provides four selectable patterns, frame-synchronous mode switching and a frame counter for animated content.

## Interface
- H_ACT, 640: active pixels per line
- V_ACT, 480: active lines per frame
- XYW, 11: width of i_x / i_y
- CW, 8: bits per colour channel
- CHECK_LOG2, 3: checkerboard tile size is 2^CHECK_LOG2 pixels
- BAR_W, 80: colour-bar width in pixels, ≥1
- i_clk  in  1  pixel clock
- i_rstn  in  1  reset: asynchronous, active-low. Clock is i_clk.
- i_de  in  1  data enable from timing generator
- i_hs  in  1  hsync, passed through
- i_vs  in  1  vsync, active-high; its rising edge marks the frame boundary
- i_x  in  XYW  current pixel column
- i_y  in  XYW  current pixel row
- i_mode  in  2  requested pattern: 0 border, 1 checker, 2 bars, 3 gradient
- o_de, o_hs, o_vs  out  1 each  i_de/i_hs/i_vs delayed by 2 cycles
- o_r, o_g, o_b  out  CW each  pixel colour

## Operation
- Full-scale ("on") is all-ones; "off" is zero.
- Active mode register: loaded from i_mode on a rising edge of i_vs (i_vs=1 and the previous i_vs=0). Changes to i_mode at any other time are ignored.
- frame_cnt (8 bits): increments on the same i_vs rising edge and wraps 255→0.
- Mode 0, border: white when x==0, x==H_ACT-1, y==0 or y==V_ACT-1; black otherwise.
- Mode 1, checker: white when x[CHECK_LOG2] XOR y[CHECK_LOG2] is 1; black otherwise.
- Mode 2, bars: bar index idx = floor(x/BAR_W), saturated at 7. Colour is R=~idx[1], G=~idx[2], B=~idx[0], giving white, yellow, cyan, green, magenta, red, blue, black.
  - idx is produced incrementally, with no divider. A column counter and idx both clear on a cycle with i_de=1 and i_x==0.
  - On every other i_de=1 cycle the column counter increments. When the counter reaches BAR_W-1 it wraps to 0 and idx increments (saturating at 7).
  - Both counters hold while i_de=0.
- Mode 3, gradient: R = x[CW-1:0], G = y[CW-1:0], B = frame_cnt zero-extended or truncated to CW bits.
- Output RGB is forced to zero whenever the delayed DE (o_de) is 0.

## Timing
- Two-stage pipeline; fixed latency of 2 cycles.
  - Stage 1 registers the pattern class and bar index.
  - Stage 2 registers the colour.
- All o_* outputs stay aligned to their input pixel.
- Reset (async assert, sync release) sets:
  - every output to 0
  - pipeline registers to 0
  - mode to 0 (border)
  - frame_cnt to 0
  - bar counters to 0
- Reset asserted mid-frame drops the output to zero immediately. After release, the first valid mode and frame_cnt update occurs at the next i_vs rising edge; until then the mode stays border.
- A mode load on the vs edge applies from the first pixel after that edge. Pixels already in the pipeline finish in the old mode.
- If i_x==0 with i_de=1 and a column-counter wrap fall on the same cycle, the clear wins.

## Configuration
- PATGEN_SCROLL_EN defined: modes 1 and 3 use the effective column x' = (i_x + frame_cnt) mod 2^XYW, so the pattern scrolls left by one pixel per frame. Modes 0 and 2 are unaffected.
- PATGEN_SCROLL_EN undefined: x' = i_x everywhere. frame_cnt still exists and still drives gradient B.

## Structure
- Shared package patgen_pkg holds:
  - mode localparams MODE_BORDER=0, MODE_CHECK=1, MODE_BARS=2, MODE_GRAD=3
  - the 3-bit bar colour table
  - the pipeline latency constant PATGEN_LAT=2, used by the timing-alignment logic downstream
- Sub-module patgen_bar_counter: column counter plus saturating idx, parametrised by BAR_W and XYW.

## Test plan
- Reset check: assert i_rstn=0 mid-line → all outputs 0 the same cycle. Release, then drive a full 640x480 frame → border mode, with pixel (0,0) white two cycles after it is presented.
- Border: in mode 0, (639,240) and (320,479) give RGB=FF/FF/FF; (320,240) gives 00/00/00; o_de/o_hs/o_vs match the inputs delayed by 2 cycles.
- Mode switch: change i_mode 0→2 mid-frame → the rest of that frame stays border. After the vs rising edge, x=0 is white, x=80 yellow, x=559 blue, x=560..639 black.
- Checker, CHECK_LOG2=3: (8,0) white, (8,8) black, (7,7) black.
- Gradient and frame-counter wrap: in mode 3, run 256 frames → B=FF on frame 255 and 00 on frame 256; at (5,9), R=05 and G=09.
- Scroll (build with PATGEN_SCROLL_EN): in mode 1, frame_cnt=8 → (0,0) white, mirroring unscrolled (8,0).
